// File: rtl/tone_seq_pkg.sv
// tone_seq_pkg: pitch period, display code and octave-flag tables plus FSM states for tone_seq_player
package tone_seq_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_e;
  localparam logic [10:0] PERIOD_TBL [16] = '{
    11'd1, 11'd1275, 11'd1136, 11'd1012, 11'd932, 11'd851, 11'd758, 11'd676,
    11'd638, 11'd568, 11'd506, 11'd448, 11'd426, 11'd380, 11'd358, 11'd320
  };
  localparam logic [3:0] CODE_TBL [16] = '{
    4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
    4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd1
  };
  localparam logic [15:0] HIGH_TBL = 16'hFF00;
endpackage

// File: rtl/tone_seq_player_div.sv
// tone_div: period-reload divider toggling the speaker square wave on each wrap
module tone_div #(
  parameter int DIV_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] period,
  output logic             spk
);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic spk_q, spk_d, wrap;
  always_comb begin
    wrap  = cnt_q == period - DIV_W'(1);
    cnt_d = clr ? '0 : en ? (wrap ? '0 : cnt_q + DIV_W'(1)) : cnt_q;
    spk_d = clr ? 1'b0 : (en && wrap) ? ~spk_q : spk_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      spk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      spk_q <= spk_d;
    end
  end
  assign spk = spk_q;
endmodule

// File: rtl/tone_seq_player.sv
// tone_seq_player: handshaked note player driving speaker square wave and display digit.
// Optional TONE_ARTIC_EN silences the last beat of multi-beat notes.
module tone_seq_player
  import tone_seq_pkg::*;
#(
  parameter int OCT_W  = 2,
  parameter int BEAT_W = 4,
  parameter int DIV_W  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              note_valid,
  output logic              note_ready,
  input  logic [3:0]        note_idx,
  input  logic [OCT_W-1:0]  note_oct,
  input  logic [BEAT_W-1:0] note_beats,
  input  logic              div_tick,
  input  logic              beat_tick,
  output logic              spk,
  output logic [3:0]        code,
  output logic              high,
  output logic              busy,
  output logic              done
);
  state_e state_q, state_d;
  logic [3:0] idx_q, idx_d, code_q, code_d;
  logic high_q, high_d;
  logic [OCT_W-1:0] oct_q, oct_d;
  logic [BEAT_W-1:0] beats_q, beats_d, rem_q, rem_d;
  logic [DIV_W-1:0] period_q, period_d, shifted;
  logic end_note, spk_div;
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    oct_d    = oct_q;
    beats_d  = beats_q;
    rem_d    = rem_q;
    period_d = period_q;
    code_d   = code_q;
    high_d   = high_q;
    shifted  = DIV_W'(PERIOD_TBL[idx_q]) >> oct_q;
    end_note = state_q == PLAY && beat_tick && rem_q == BEAT_W'(1);
    done     = end_note && !rst;
    case (state_q)
      IDLE: if (note_valid) begin
        idx_d   = note_idx;
        oct_d   = note_oct;
        beats_d = (note_beats == '0) ? BEAT_W'(1) : note_beats;
        state_d = LOAD;
      end
      LOAD: begin
        period_d = (shifted == '0) ? DIV_W'(1) : shifted;
        code_d   = CODE_TBL[idx_q];
        high_d   = HIGH_TBL[idx_q];
        rem_d    = beats_q;
        state_d  = PLAY;
      end
      PLAY: if (end_note) begin
        rem_d   = '0;
        state_d = IDLE;
      end else if (beat_tick) begin
        rem_d = rem_q - BEAT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      oct_q    <= '0;
      beats_q  <= '0;
      rem_q    <= '0;
      period_q <= '0;
      code_q   <= '0;
      high_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      oct_q    <= oct_d;
      beats_q  <= beats_d;
      rem_q    <= rem_d;
      period_q <= period_d;
      code_q   <= code_d;
      high_q   <= high_d;
    end
  end
  // Ending the note clears the divider so spk drops even if a toggle tick coincides
  tone_div #(.DIV_W(DIV_W)) u_div (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == LOAD || end_note),
    .en     (state_q == PLAY && div_tick && idx_q != '0),
    .period (period_q),
    .spk    (spk_div)
  );
`ifdef TONE_ARTIC_EN
  assign spk = spk_div && !(state_q == PLAY && rem_q == BEAT_W'(1) && beats_q > BEAT_W'(1));
`else
  assign spk = spk_div;
`endif
  assign note_ready = state_q == IDLE;
  assign busy       = state_q != IDLE;
  assign code       = code_q;
  assign high       = high_q;
endmodule

// File: tb/tb_tone_seq_player.sv
// tb_tone_seq_player: table vectors, corner sequences and random traffic against a note-level model
module tb_tone_seq_player;
  logic clk = 1'b0, rst, note_valid, note_ready, div_tick, beat_tick, spk, high, busy, done;
  logic [3:0] note_idx, note_beats, code;
  logic [1:0] note_oct;
  always #5 clk = ~clk;

  tone_seq_player dut (
    .clk(clk), .rst(rst), .note_valid(note_valid), .note_ready(note_ready),
    .note_idx(note_idx), .note_oct(note_oct), .note_beats(note_beats),
    .div_tick(div_tick), .beat_tick(beat_tick), .spk(spk), .code(code),
    .high(high), .busy(busy), .done(done)
  );

`ifdef TONE_ARTIC_EN
  localparam int ARTIC = 1;
`else
  localparam int ARTIC = 0;
`endif

  int checks = 0, errors = 0;
  int per_tbl [16] = '{1, 1275, 1136, 1012, 932, 851, 758, 676, 638, 568, 506, 448, 426, 380, 358, 320};
  // model: ms 0 idle, 1 load, 2 play; m_n counts div_ticks seen while playing
  int ms = 0, m_idx = 0, m_oct = 0, m_beats = 0, m_rem = 0, m_per = 1, m_n = 0, m_code = 0, m_high = 0;
  int s_spk, s_done, s_ready, s_busy, s_code, s_high;

  typedef struct { int idx; int oct; int beats; int per; int code; int high; } vec_t;
  vec_t vecs [5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_spk();
    if (ms != 2 || m_idx == 0) return 0;
    if (ARTIC != 0 && m_rem == 1 && m_beats > 1) return 0;
    return (m_n / m_per) % 2;
  endfunction

  task automatic cyc(input int v, input int i, input int o, input int b, input int dt, input int bt, input int r);
    @(negedge clk);
    rst = (r != 0); note_valid = (v != 0); note_idx = 4'(i); note_oct = 2'(o);
    note_beats = 4'(b); div_tick = (dt != 0); beat_tick = (bt != 0);
    #1;
    s_spk = int'(spk); s_done = int'(done); s_ready = int'(note_ready);
    s_busy = int'(busy); s_code = int'(code); s_high = int'(high);
    chk("spk", s_spk, exp_spk());
    chk("note_ready", s_ready, int'(ms == 0));
    chk("busy", s_busy, int'(ms != 0));
    chk("done", s_done, int'(ms == 2 && bt != 0 && m_rem == 1 && r == 0));
    chk("code", s_code, m_code);
    chk("high", s_high, m_high);
    if (r != 0) begin
      ms = 0; m_code = 0; m_high = 0; m_rem = 0; m_n = 0;
    end else if (ms == 0) begin
      if (v != 0) begin
        m_idx = i & 15; m_oct = o & 3; m_beats = ((b & 15) == 0) ? 1 : (b & 15); ms = 1;
      end
    end else if (ms == 1) begin
      m_per = per_tbl[m_idx] >> m_oct;
      if (m_per < 1) m_per = 1;
      m_code = (m_idx == 0) ? 0 : ((m_idx - 1) % 7) + 1;
      m_high = int'(m_idx >= 8);
      m_rem = m_beats; m_n = 0; ms = 2;
    end else if (bt != 0 && m_rem == 1) begin
      ms = 0; m_rem = 0;
    end else begin
      if (bt != 0) m_rem--;
      if (dt != 0 && m_idx != 0) m_n++;
    end
  endtask

  task automatic play_vec(input vec_t t);
    int n, any;
    cyc(1, t.idx, t.oct, t.beats, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    n = 0;
    do begin cyc(0, 0, 0, 0, 1, 0, 0); n++; end while (s_spk != 1 && n < 4000);
    chk("first_toggle_ticks", n - 1, t.per);
    chk("vec_code", s_code, t.code);
    chk("vec_high", s_high, t.high);
    n = 0;
    do begin cyc(0, 0, 0, 0, 1, 0, 0); n++; end while (s_spk != 0 && n < 4000);
    chk("half_period_ticks", n, t.per);
    for (int k = 0; k < t.beats - 1; k++) cyc(0, 0, 0, 0, 0, 1, 0);
    if (t.beats > 1) begin
      any = 0;
      for (int k = 0; k < 2 * t.per + 2; k++) begin
        cyc(0, 0, 0, 0, 1, 0, 0);
        any = any | s_spk;
      end
      chk("last_beat_sound", any, 1 - ARTIC);
    end
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("vec_done", s_done, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("vec_spk_after", s_spk, 0);
    chk("vec_ready_after", s_ready, 1);
  endtask

  initial begin
    vecs[0] = '{1, 0, 2, 1275, 1, 0};
    vecs[1] = '{15, 2, 1, 80, 1, 1};
    vecs[2] = '{5, 0, 3, 851, 5, 0};
    vecs[3] = '{9, 1, 1, 284, 2, 1};
    vecs[4] = '{14, 3, 2, 44, 7, 1};
    rst = 1'b1; note_valid = 1'b0; note_idx = '0; note_oct = '0; note_beats = '0;
    div_tick = 1'b0; beat_tick = 1'b0;
    repeat (2) @(posedge clk);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("reset_ready", s_ready, 1);
    chk("reset_busy", s_busy, 0);
    chk("reset_spk", s_spk, 0);
    for (int v = 0; v < 5; v++) play_vec(vecs[v]);
    // code/high hold the last note while idle
    cyc(0, 0, 0, 0, 1, 1, 0);
    chk("hold_code", s_code, 7);
    chk("hold_high", s_high, 1);
    // rest with zero beats
    cyc(1, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 0, 0, 1, 0, 0);
      chk("rest_spk", s_spk, 0);
    end
    chk("rest_code", s_code, 0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    chk("rest_done", s_done, 1);
    // final beat coincident with a toggling div_tick
    cyc(1, 15, 3, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 39; k++) cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    chk("coinc_done", s_done, 1);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("coinc_spk", s_spk, 0);
    // note_valid during PLAY is ignored
    cyc(1, 2, 0, 2, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(1, 7, 1, 5, 1, 0, 0);
    chk("play_ready", s_ready, 0);
    cyc(1, 7, 1, 5, 1, 0, 0);
    chk("play_code_kept", s_code, 2);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("play_done", s_done, 1);
    // reset mid-note: no done pulse
    cyc(1, 3, 2, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 300; k++) cyc(0, 0, 0, 0, 1, 0, 0);
    chk("pre_rst_spk", s_spk, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 0, 1, 1, 1);
      chk("rst_no_done", s_done, 0);
    end
    cyc(0, 0, 0, 0, 1, 1, 0);
    chk("rst_spk", s_spk, 0);
    chk("rst_busy", s_busy, 0);
    chk("rst_ready", s_ready, 1);
    chk("rst_done", s_done, 0);
    for (int c = 0; c < 20000; c++)
      cyc(int'($urandom_range(0, 3) == 0), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), int'($urandom_range(0, 40) == 0),
          int'($urandom_range(0, 3000) == 0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
